// File: rtl/aemb2_xsl_pkg.sv
// Shared types and constants for the aeMB2 XSL bus arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   xsl_state_e  - arbiter FSM states (IDLE = 1'b0, BUSY = 1'b1)
//   XSL_SEL_ALL  - byte select driven on every XSL slave access
//   XSL_TMO_W    - width of the bus watchdog counter
//   xsl_adr_w()  - channel-field width for a given XSL address width
package aemb2_xsl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } xsl_state_e;

  // XSL transfers are always full 32-bit words.
  localparam logic [3:0] XSL_SEL_ALL = 4'hF;

  localparam int XSL_TMO_W = 8;

  // The channel field is adr[AEMB_XWB-1:2]; the two low byte-lane bits are
  // never carried on the bus.
  function automatic int xsl_adr_w(input int xwb);
    return xwb - 2;
  endfunction

endpackage

// File: rtl/aemb2_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... mod NMST.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
//
// Ports:
//   req  in  NMST  request vector
//   ptr  in  PW    highest-priority index for this scan
//   gnt  out NMST  one-hot selected requester (all zero when vld = 0)
//   idx  out PW    binary index of the selected requester
//   vld  out 1     at least one request is present
module aemb2_rr_pick #(
  parameter int NMST = 2,
  parameter int PW   = (NMST > 1) ? $clog2(NMST) : 1
) (
  input  logic [NMST-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NMST-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < NMST; i++) begin
      int c;
      // Explicit wrap so NMST need not be a power of two.
      c = int'(ptr) + i;
      if (c >= NMST) c = c - NMST;
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/aemb2_xsl_arbiter.sv
// Shares one XSL accelerator slave between NMST aeMB2 XSL masters, round-robin.
// Latency: 1 cycle from a request seen in IDLE to s_stb_o; acks pass through combinationally.
// Backpressure: losing masters hold stb until granted; watchdog ends hung transfers with an error ack.
//
// Ports:
//   gclk, grst                       clock, synchronous active-high reset
//   m_stb_i/m_wre_i/m_tag_i [NMST]   per-master strobe, write (PUT) and control-tag flags
//   m_adr_i [NMST*W], m_dat_i [NMST*32]  per-master channel and write data, master k at [k*W +: W]
//   m_ack_o [NMST], m_err_o          per-master ack (one-hot), timeout qualifier
//   m_dat_o [32]                     slave read data broadcast to all masters
//   s_adr_o/s_dat_o/s_sel_o/s_wre_o/s_tag_o/s_stb_o/s_cyc_o   registered slave-side request
//   s_dat_i [32], s_ack_i            slave read data and acknowledge
module aemb2_xsl_arbiter
  import aemb2_xsl_pkg::*;
#(
  parameter int AEMB_XWB = 3,
  parameter int NMST     = 2,
  parameter int TMO      = 255
) (
  input  logic                                 gclk,
  input  logic                                 grst,
  input  logic [NMST-1:0]                      m_stb_i,
  input  logic [NMST*xsl_adr_w(AEMB_XWB)-1:0]  m_adr_i,
  input  logic [NMST*32-1:0]                   m_dat_i,
  input  logic [NMST-1:0]                      m_wre_i,
  input  logic [NMST-1:0]                      m_tag_i,
  output logic [NMST-1:0]                      m_ack_o,
  output logic                                 m_err_o,
  output logic [31:0]                          m_dat_o,
  output logic [xsl_adr_w(AEMB_XWB)-1:0]       s_adr_o,
  output logic [31:0]                          s_dat_o,
  output logic [3:0]                           s_sel_o,
  output logic                                 s_wre_o,
  output logic                                 s_tag_o,
  output logic                                 s_stb_o,
  output logic                                 s_cyc_o,
  input  logic [31:0]                          s_dat_i,
  input  logic                                 s_ack_i
);

  localparam int W  = xsl_adr_w(AEMB_XWB);
  localparam int PW = (NMST > 1) ? $clog2(NMST) : 1;

  localparam bit                   TMO_EN = (TMO != 0);
  localparam logic [XSL_TMO_W-1:0] TMO_M1 = (TMO == 0) ? '0 : XSL_TMO_W'(TMO - 1);

  typedef struct packed {
    logic [W-1:0] adr;
    logic [31:0]  dat;
    logic         wre;
    logic         tag;
  } xsl_req_t;

  xsl_state_e           state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [XSL_TMO_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 stb_q, stb_d;
  xsl_req_t             req_q, req_d;
  xsl_req_t             req_sel;

  logic [NMST-1:0]      pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;

  logic                 busy;
  logic                 g_stb;
  logic                 tmo_hit;
  logic                 ack_any;

  aemb2_rr_pick #(
    .NMST (NMST),
    .PW   (PW)
  ) u_pick (
    .req (m_stb_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // AND-OR mux of the winning master's request fields, steered by the one-hot pick.
  always_comb begin
    req_sel = '0;
    for (int k = 0; k < NMST; k++) begin
      if (pick_gnt[k]) begin
        req_sel.adr = m_adr_i[k*W +: W];
        req_sel.dat = m_dat_i[k*32 +: 32];
        req_sel.wre = m_wre_i[k];
        req_sel.tag = m_tag_i[k];
      end
    end
  end

  assign busy  = (state_q == BUSY);
  assign g_stb = m_stb_i[gnt_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    req_d   = req_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          gnt_d   = pick_idx;
          req_d   = req_sel;
          stb_d   = 1'b1;
          cnt_d   = '0;
          // tmo_q tracks "counter == TMO-1 this cycle", so TMO = 1 fires on the first BUSY cycle.
          tmo_d   = TMO_EN && (TMO_M1 == '0);
        end
      end
      BUSY: begin
        // Ack, watchdog expiry or the owner dropping its strobe all end the transfer.
        if (s_ack_i || tmo_q || !g_stb) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          cnt_d   = '0;
          ptr_d   = (gnt_q == PW'(NMST - 1)) ? '0 : gnt_q + PW'(1);
        end else begin
          cnt_d = cnt_q + XSL_TMO_W'(1);
          tmo_d = TMO_EN && (cnt_d == TMO_M1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      stb_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      req_q   <= req_d;
    end
  end

  // A timeout only terminates a master that is still waiting; a real ack in
  // the same cycle takes precedence and clears the error qualifier.
  assign tmo_hit = busy & tmo_q & g_stb;
  assign ack_any = busy & (s_ack_i | tmo_hit);
  assign m_err_o = tmo_hit & ~s_ack_i;

  always_comb begin
    m_ack_o = '0;
    for (int k = 0; k < NMST; k++) begin
      m_ack_o[k] = ack_any && (gnt_q == PW'(k));
    end
  end

  assign m_dat_o = s_dat_i;

  assign s_adr_o = req_q.adr;
  assign s_dat_o = req_q.dat;
  assign s_wre_o = req_q.wre;
  assign s_tag_o = req_q.tag;
  assign s_stb_o = stb_q;
  assign s_cyc_o = stb_q;
  assign s_sel_o = XSL_SEL_ALL;

endmodule

// File: tb/tb_aemb2_xsl_arbiter.sv
// Directed bench for aemb2_xsl_arbiter with a transaction-level reference model.
module tb_aemb2_xsl_arbiter;

  localparam int NMST = 2;
  localparam int W    = 1;
  localparam int TMO  = 4;

  logic              gclk = 1'b0;
  logic              grst;
  logic [NMST-1:0]   m_stb_i, m_wre_i, m_tag_i;
  logic [NMST*W-1:0] m_adr_i;
  logic [NMST*32-1:0] m_dat_i;
  logic [NMST-1:0]   m_ack_o;
  logic              m_err_o;
  logic [31:0]       m_dat_o;
  logic [W-1:0]      s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_wre_o, s_tag_o, s_stb_o, s_cyc_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i;

  aemb2_xsl_arbiter #(
    .AEMB_XWB (3),
    .NMST     (NMST),
    .TMO      (TMO)
  ) dut (
    .gclk    (gclk),
    .grst    (grst),
    .m_stb_i (m_stb_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_wre_i (m_wre_i),
    .m_tag_i (m_tag_i),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_dat_o (m_dat_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_wre_o (s_wre_o),
    .s_tag_o (s_tag_o),
    .s_stb_o (s_stb_o),
    .s_cyc_o (s_cyc_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i)
  );

  always #5 gclk = ~gclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner = master holding the slave (-1 when free),
  // age = how many cycles the slave has been strobed for it, rr = first
  // master to consider at the next arbitration.
  int           owner = -1;
  int           age   = 0;
  int           rr    = 0;
  int           ncyc  = 0;
  logic [W-1:0] l_adr = '0;
  logic [31:0]  l_dat = '0;
  logic         l_wre = 1'b0;
  logic         l_tag = 1'b0;

  always @(posedge gclk) begin : model
    int p;
    p = -1;
    ncyc <= ncyc + 1;
    if (grst) begin
      owner <= -1;
      age   <= 0;
      rr    <= 0;
      l_adr <= '0;
      l_dat <= '0;
      l_wre <= 1'b0;
      l_tag <= 1'b0;
    end else if (owner < 0) begin
      for (int i = 0; i < NMST; i++)
        if (p < 0 && m_stb_i[(rr + i) % NMST]) p = (rr + i) % NMST;
      if (p >= 0) begin
        owner <= p;
        age   <= 1;
        l_adr <= m_adr_i[p*W +: W];
        l_dat <= m_dat_i[p*32 +: 32];
        l_wre <= m_wre_i[p];
        l_tag <= m_tag_i[p];
      end
    end else if (s_ack_i || age == TMO || !m_stb_i[owner]) begin
      rr    <= (owner + 1) % NMST;
      owner <= -1;
    end else begin
      age <= age + 1;
    end
  end

  always @(negedge gclk) begin : compare
    logic            busy, tmo;
    logic [NMST-1:0] eack;
    if (ncyc > 0) begin
      busy = (owner >= 0);
      tmo  = busy ? (age == TMO && m_stb_i[owner]) : 1'b0;
      eack = '0;
      if (busy && (s_ack_i || tmo)) eack[owner] = 1'b1;
      chk("s_stb", 32'(s_stb_o), 32'(busy));
      chk("s_cyc", 32'(s_cyc_o), 32'(busy));
      chk("s_sel", 32'(s_sel_o), 32'hF);
      chk("m_ack", 32'(m_ack_o), 32'(eack));
      chk("m_err", 32'(m_err_o), 32'(tmo && !s_ack_i));
      chk("m_dat", m_dat_o, s_dat_i);
      if (busy) begin
        chk("s_adr", 32'(s_adr_o), 32'(l_adr));
        chk("s_dat", s_dat_o, l_dat);
        chk("s_wre", 32'(s_wre_o), 32'(l_wre));
        chk("s_tag", 32'(s_tag_o), 32'(l_tag));
      end
    end
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  int seq[$];
  int exp_seq[4] = '{1, 0, 1, 0};

  initial begin
    grst = 1'b1;
    m_stb_i = '0; m_wre_i = '0; m_tag_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    tick(); tick();
    @(negedge gclk);
    chk("rst_stb", 32'(s_stb_o), 0);
    chk("rst_ack", 32'(m_ack_o), 0);
    chk("rst_err", 32'(m_err_o), 0);
    chk("rst_adr", 32'(s_adr_o), 0);
    chk("rst_dat", s_dat_o, 0);
    chk("rst_wre", 32'(s_wre_o), 0);
    chk("rst_tag", 32'(s_tag_o), 0);
    tick();
    grst = 1'b0;

    // Single PUT from master 0, slave acks two cycles after the strobe rises.
    m_stb_i = 2'b01; m_adr_i = 2'b01; m_dat_i[31:0] = 32'hDEADBEEF; m_wre_i = 2'b01;
    @(negedge gclk);
    chk("t1_arb_cycle_stb", 32'(s_stb_o), 0);
    tick();
    @(negedge gclk);
    chk("t1_stb_rise", 32'(s_stb_o), 1);
    chk("t1_adr", 32'(s_adr_o), 1);
    chk("t1_dat", s_dat_o, 32'hDEADBEEF);
    chk("t1_wre", 32'(s_wre_o), 1);
    chk("t1_no_early_ack", 32'(m_ack_o), 0);
    tick(); tick();
    s_ack_i = 1'b1;
    @(negedge gclk);
    chk("t1_ack", 32'(m_ack_o), 32'b01);
    tick();
    s_ack_i = 1'b0; m_stb_i = 2'b00;
    @(negedge gclk);
    chk("t1_stb_fall", 32'(s_stb_o), 0);

    // Contention with a one-cycle slave; priority is at master 1 after the last transfer.
    tick();
    m_stb_i = 2'b11; m_adr_i = 2'b10; m_dat_i = {32'hB1B10001, 32'hA0A00000};
    m_wre_i = 2'b01; m_tag_i = 2'b10;
    for (int i = 0; i < 8; i++) begin
      @(negedge gclk);
      if (m_ack_o == 2'b01) seq.push_back(0);
      else if (m_ack_o == 2'b10) seq.push_back(1);
      tick();
      s_ack_i = s_stb_o;
    end
    m_stb_i = 2'b00;
    chk("t2_num_grants", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_grant_order", (i < seq.size()) ? seq[i] : 99, exp_seq[i]);

    // GET by master 1 with read data returned alongside the ack.
    tick();
    m_stb_i = 2'b10; m_wre_i = 2'b00; m_tag_i = 2'b00;
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'h12345678;
    @(negedge gclk);
    chk("t3_rdata", m_dat_o, 32'h12345678);
    chk("t3_ack", 32'(m_ack_o), 32'b10);
    chk("t3_err", 32'(m_err_o), 0);
    tick();
    s_ack_i = 1'b0; s_dat_i = '0; m_stb_i = 2'b00;
    @(negedge gclk);
    chk("t3_stb_fall", 32'(s_stb_o), 0);

    // Watchdog: slave never answers master 0.
    tick();
    m_stb_i = 2'b01; m_dat_i[31:0] = 32'hC0DE0000;
    tick();
    @(negedge gclk);
    chk("t4_stb", 32'(s_stb_o), 1);
    tick(); tick(); tick();
    @(negedge gclk);
    chk("t4_tmo_ack", 32'(m_ack_o), 32'b01);
    chk("t4_tmo_err", 32'(m_err_o), 1);
    tick();
    m_stb_i = 2'b00;
    @(negedge gclk);
    chk("t4_stb_fall", 32'(s_stb_o), 0);
    chk("t4_no_ack", 32'(m_ack_o), 0);
    tick();
    m_stb_i = 2'b11; m_dat_i[63:32] = 32'hD1D1D1D1;
    tick();
    s_ack_i = 1'b1;
    @(negedge gclk);
    chk("t4_ptr_adv_dat", s_dat_o, 32'hD1D1D1D1);
    chk("t4_ptr_adv_ack", 32'(m_ack_o), 32'b10);
    tick();
    s_ack_i = 1'b0; m_stb_i = 2'b00;

    // Ack arriving in the very cycle the watchdog fires.
    tick();
    m_stb_i = 2'b01;
    tick(); tick(); tick(); tick();
    s_ack_i = 1'b1;
    @(negedge gclk);
    chk("t4b_ack", 32'(m_ack_o), 32'b01);
    chk("t4b_err", 32'(m_err_o), 0);
    tick();
    s_ack_i = 1'b0; m_stb_i = 2'b00;
    @(negedge gclk);
    chk("t4b_stb_fall", 32'(s_stb_o), 0);

    // Abort: master 0 withdraws in its second BUSY cycle.
    tick();
    m_stb_i = 2'b01;
    tick(); tick();
    m_stb_i = 2'b00;
    @(negedge gclk);
    chk("t5_abort_no_ack", 32'(m_ack_o), 0);
    tick();
    @(negedge gclk);
    chk("t5_stb_fall", 32'(s_stb_o), 0);
    chk("t5_no_ack", 32'(m_ack_o), 0);

    // Reset in the middle of a transfer, followed by a stale slave ack.
    tick();
    m_stb_i = 2'b01; m_wre_i = 2'b01; m_tag_i = 2'b01;
    tick();
    @(negedge gclk);
    chk("t6_busy", 32'(s_stb_o), 1);
    grst = 1'b1;
    tick();
    grst = 1'b0; s_ack_i = 1'b1; m_stb_i = 2'b00;
    @(negedge gclk);
    chk("t6_stb", 32'(s_stb_o), 0);
    chk("t6_adr", 32'(s_adr_o), 0);
    chk("t6_dat", s_dat_o, 0);
    chk("t6_wre", 32'(s_wre_o), 0);
    chk("t6_tag", 32'(s_tag_o), 0);
    chk("t6_stale_ack", 32'(m_ack_o), 0);
    chk("t6_err", 32'(m_err_o), 0);
    tick();
    s_ack_i = 1'b0; m_stb_i = 2'b11;
    tick();
    s_ack_i = 1'b1;
    @(negedge gclk);
    chk("t6_ptr_reset_ack", 32'(m_ack_o), 32'b01);
    tick();
    s_ack_i = 1'b0; m_stb_i = 2'b00;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
